// File: rtl/clkdiv_prog.sv
// NCH programmable clock dividers; oclk/tick registered (1 cycle after cnt); a single config slot drops cfg_ready until it commits at the target's wrap.
// Build option CLKDIV_SYNC_EN adds a sync input that restarts every enabled channel at phase 0 together.
module clkdiv_prog #(
    parameter int NCH     = 4,
    parameter int CW      = 16,
    parameter int DIV_RST = 10,
    localparam int CHW    = (NCH > 1) ? $clog2(NCH) : 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [NCH-1:0]  en,
`ifdef CLKDIV_SYNC_EN
    input  logic            sync,
`endif
    input  logic            cfg_valid,
    output logic            cfg_ready,
    input  logic [CHW-1:0]  cfg_ch,
    input  logic [CW-1:0]   cfg_div,
    input  logic [CW-1:0]   cfg_high,
    output logic [NCH-1:0]  oclk,
    output logic [NCH-1:0]  tick
);

    localparam int DIVR  = (DIV_RST < 2) ? 2 : DIV_RST;
    localparam int HIGHR = (DIVR / 2 < 1) ? 1 : DIVR / 2;

    logic [NCH-1:0][CW-1:0] cnt_q, cnt_d;
    logic [NCH-1:0][CW-1:0] div_q, div_d;
    logic [NCH-1:0][CW-1:0] high_q, high_d;
    logic [NCH-1:0]         oclk_q, oclk_d;
    logic [NCH-1:0]         tick_q, tick_d;
    logic                   pend_q, pend_d;
    logic [CHW-1:0]         pch_q, pch_d;
    logic [CW-1:0]          pdiv_q, pdiv_d;
    logic [CW-1:0]          phigh_q, phigh_d;

    logic                   sync_w;
    logic                   commit;
    logic                   ch_ok;
    logic [CW-1:0]          cdiv;
    logic [CW-1:0]          chigh;
    logic [NCH-1:0]         wrap;

`ifdef CLKDIV_SYNC_EN
    assign sync_w = sync;
`else
    assign sync_w = 1'b0;
`endif

    assign cfg_ready = ~pend_q;
    assign oclk      = oclk_q;
    assign tick      = tick_q;

    always_comb begin
        cdiv   = (pdiv_q < CW'(2)) ? CW'(2) : pdiv_q;
        chigh  = (phigh_q == '0) ? CW'(1) :
                 ((phigh_q >= cdiv) ? (cdiv - CW'(1)) : phigh_q);
        ch_ok  = (int'(pch_q) < NCH);
        commit = 1'b0;
        wrap   = '0;
        for (int i = 0; i < NCH; i++) begin
            wrap[i] = (cnt_q[i] == div_q[i] - CW'(1));
        end
        // Committing only at the wrap (or while idle) keeps both old and new pulse widths intact.
        if (pend_q) begin
            if (!ch_ok) begin
                commit = 1'b1;
            end else begin
                for (int i = 0; i < NCH; i++) begin
                    if (pch_q == CHW'(i) && (!en[i] || wrap[i] || sync_w)) begin
                        commit = 1'b1;
                    end
                end
            end
        end

        for (int i = 0; i < NCH; i++) begin
            cnt_d[i]  = (!en[i] || sync_w || wrap[i]) ? '0 : cnt_q[i] + CW'(1);
            oclk_d[i] = en[i] && (cnt_q[i] < high_q[i]);
            tick_d[i] = en[i] && wrap[i] && !sync_w;
            div_d[i]  = div_q[i];
            high_d[i] = high_q[i];
            if (commit && ch_ok && pch_q == CHW'(i)) begin
                div_d[i]  = cdiv;
                high_d[i] = chigh;
            end
        end

        pend_d  = pend_q;
        pch_d   = pch_q;
        pdiv_d  = pdiv_q;
        phigh_d = phigh_q;
        if (commit) begin
            pend_d = 1'b0;
        end else if (cfg_valid && !pend_q) begin
            pend_d  = 1'b1;
            pch_d   = cfg_ch;
            pdiv_d  = cfg_div;
            phigh_d = cfg_high;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q   <= '0;
            div_q   <= {NCH{CW'(DIVR)}};
            high_q  <= {NCH{CW'(HIGHR)}};
            oclk_q  <= '0;
            tick_q  <= '0;
            pend_q  <= 1'b0;
            pch_q   <= '0;
            pdiv_q  <= '0;
            phigh_q <= '0;
        end else begin
            cnt_q   <= cnt_d;
            div_q   <= div_d;
            high_q  <= high_d;
            oclk_q  <= oclk_d;
            tick_q  <= tick_d;
            pend_q  <= pend_d;
            pch_q   <= pch_d;
            pdiv_q  <= pdiv_d;
            phigh_q <= phigh_d;
        end
    end

endmodule
